button_debouncer: RTL and testbench

//  Multi-channel debouncer replacing the single hard-wired reset-button debounce in FPGA tops.

---
 rtl/CPU_pkg.sv | 11 +
 rtl/debounce_channel.sv | 65 ++++++
 rtl/button_debouncer.sv | 63 ++++++
 tb/tb_button_debouncer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/CPU_pkg.sv
// Shared constants and parameter helpers for the button debouncer slice.
package CPU_pkg;

    localparam int US_PER_S = 1_000_000;

    // Sample interval in clk cycles for a given clock and period.
    function automatic int tick_cycles(input int freq_hz, input int period_us);
        return freq_hz / US_PER_S * period_us;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: 2-flop synchroniser, sample history window, level
// tracking with edge pulses and a saturating long-press counter.
module debounce_channel #(
    parameter int   SAMPLES      = 4,
    parameter int   LONG_SAMPLES = 333,
    parameter logic INVERT       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_tick,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_pulse
);

    localparam int LCW = $clog2(LONG_SAMPLES + 1);
    localparam logic [LCW-1:0] LONG_MAX  = LCW'(LONG_SAMPLES);
    localparam logic [LCW-1:0] LONG_LAST = LCW'(LONG_SAMPLES - 1);

    logic [1:0]         sync_pipe;
    logic [SAMPLES-2:0] hist;
    logic [SAMPLES-1:0] window;
    logic [LCW-1:0]     long_cnt;

    // Newest sample sits in bit 0; the window includes the sample being taken now.
    assign window = {hist, sync_pipe[1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_pipe  <= '0;
            hist       <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            long_pulse <= 1'b0;
            long_cnt   <= '0;
        end else begin
            sync_pipe  <= {sync_pipe[0], btn_in ^ INVERT};
            rise       <= 1'b0;
            fall       <= 1'b0;
            long_pulse <= 1'b0;
            if (!level)
                long_cnt <= '0;
            if (sample_tick) begin
                hist <= window[SAMPLES-2:0];
                if (&window && !level) begin
                    level <= 1'b1;
                    rise  <= 1'b1;
                end else if (~|window && level) begin
                    level <= 1'b0;
                    fall  <= 1'b1;
                end
                // Saturates at LONG_MAX so the pulse fires once per press.
                if (level && long_cnt != LONG_MAX) begin
                    long_cnt <= long_cnt + LCW'(1);
                    if (long_cnt == LONG_LAST)
                        long_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: shared sample prescaler plus one
// debounce_channel per input.
module button_debouncer
    import CPU_pkg::*;
#(
    parameter int                  CHANNELS         = 4,
    parameter int                  CLK_FREQ_HZ      = 16_000_000,
    parameter int                  SAMPLE_PERIOD_US = 3000,
    parameter int                  SAMPLES          = 4,
    parameter int                  LONG_SAMPLES     = 333,
    parameter logic [CHANNELS-1:0] INVERT           = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] btn_rise,
    output logic [CHANNELS-1:0] btn_fall,
    output logic [CHANNELS-1:0] btn_long,
    output logic                sample_tick
);

    localparam int TICK_CYCLES = tick_cycles(CLK_FREQ_HZ, SAMPLE_PERIOD_US);
    localparam int CW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TICK_CYCLES > 1) ? CW'(TICK_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_PRE  = (TICK_CYCLES > 1) ? CW'(TICK_CYCLES - 2) : '0;

    if (SAMPLES < 2 || TICK_CYCLES < 1 || LONG_SAMPLES <= SAMPLES) begin : g_param_err
        $error("button_debouncer: need SAMPLES>=2, TICK_CYCLES>=1, LONG_SAMPLES>SAMPLES");
    end

    logic [CW-1:0] count;

    // sample_tick is registered: it is set one cycle early so it is high
    // exactly while count sits at its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= '0;
            sample_tick <= 1'b0;
        end else begin
            count       <= (count == CNT_LAST) ? '0 : count + CW'(1);
            sample_tick <= (TICK_CYCLES == 1) || (count == CNT_PRE);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_channel #(
            .SAMPLES      (SAMPLES),
            .LONG_SAMPLES (LONG_SAMPLES),
            .INVERT       (INVERT[i])
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .sample_tick (sample_tick),
            .btn_in      (btn_in[i]),
            .level       (btn_level[i]),
            .rise        (btn_rise[i]),
            .fall        (btn_fall[i]),
            .long_pulse  (btn_long[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised and directed bench for button_debouncer against a sample-list
// reference model.
module tb_button_debouncer;

    localparam int NCH  = 2;
    localparam int T    = 10;
    localparam int S    = 4;
    localparam int LONG = 8;
    localparam logic [NCH-1:0] INV = 2'b10;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NCH-1:0] btn_in;
    logic [NCH-1:0] btn_level, btn_rise, btn_fall, btn_long;
    logic           sample_tick;

    button_debouncer #(
        .CHANNELS(NCH), .CLK_FREQ_HZ(1_000_000), .SAMPLE_PERIOD_US(10),
        .SAMPLES(S), .LONG_SAMPLES(LONG), .INVERT(INV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
        .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
        .btn_long(btn_long), .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            if (errs <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sample instants are every T-th edge after release,
    // each sample is the effective input captured two edges earlier.
    int k;
    int tick_no;
    bit inq[NCH][$];
    bit smp[NCH][$];
    int rise_tick[NCH];
    logic [NCH-1:0] m_level, m_rise, m_fall, m_long;
    logic           m_tick;

    task automatic model_edge();
        if (!reset_n) begin
            k = 0; tick_no = 0;
            m_level = '0; m_rise = '0; m_fall = '0; m_long = '0; m_tick = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                inq[c].delete(); smp[c].delete(); rise_tick[c] = 0;
            end
            return;
        end
        k++;
        m_rise = '0; m_fall = '0; m_long = '0;
        if (k % T == 0) begin
            tick_no++;
            for (int c = 0; c < NCH; c++) begin
                bit s;
                int ones;
                s = (k >= 3) ? inq[c][k-3] : 1'b0;
                smp[c].push_back(s);
                ones = 0;
                for (int j = 0; j < S; j++) begin
                    int idx;
                    idx = smp[c].size() - 1 - j;
                    if (idx >= 0 && smp[c][idx]) ones++;
                end
                if (m_level[c] && tick_no - rise_tick[c] == LONG) m_long[c] = 1'b1;
                if (ones == S && !m_level[c]) begin
                    m_level[c] = 1'b1; m_rise[c] = 1'b1; rise_tick[c] = tick_no;
                end else if (ones == 0 && m_level[c]) begin
                    m_level[c] = 1'b0; m_fall[c] = 1'b1;
                end
            end
        end
        for (int c = 0; c < NCH; c++) inq[c].push_back(btn_in[c] ^ INV[c]);
        m_tick = (k % T == T - 1);
    endtask

    // Observation bookkeeping for the directed checks.
    int cyc = 0;
    int n_rise[NCH], n_fall[NCH], n_long[NCH];
    int rise_cyc[NCH], long_cyc[NCH], rise_k[NCH];
    int ticks_since_rel, tk1, tk2;

    initial begin
        for (int c = 0; c < NCH; c++) begin
            n_rise[c] = 0; n_fall[c] = 0; n_long[c] = 0;
            rise_cyc[c] = 0; long_cyc[c] = 0; rise_k[c] = 0;
        end
        ticks_since_rel = 0; tk1 = -1; tk2 = -1;
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        model_edge();
        chk("sample_tick", sample_tick, m_tick);
        chk("btn_level", btn_level, m_level);
        chk("btn_rise", btn_rise, m_rise);
        chk("btn_fall", btn_fall, m_fall);
        chk("btn_long", btn_long, m_long);
        if (!reset_n) begin
            ticks_since_rel = 0;
        end else if (sample_tick) begin
            if (ticks_since_rel == 0) tk1 = k;
            else if (ticks_since_rel == 1) tk2 = k;
            ticks_since_rel++;
        end
        for (int c = 0; c < NCH; c++) begin
            if (btn_rise[c]) begin n_rise[c]++; rise_cyc[c] = cyc; rise_k[c] = k; end
            if (btn_fall[c]) n_fall[c]++;
            if (btn_long[c]) begin n_long[c]++; long_cyc[c] = cyc; end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        int seen, budget;
        seen = 0; budget = n * T + 20;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            if (sample_tick) seen++;
            budget--;
        end
        if (seen < n) chk("tick_wait", seen, n);
    endtask

    int r0, f0, l0, r1;

    initial begin
        reset_n = 1'b0;
        btn_in  = NCH'($urandom_range(0, 3));
        wait_cycles(5);
        chk("reset_outputs", {btn_level, btn_rise, btn_fall, btn_long, sample_tick}, 0);
        btn_in = 2'b10;
        reset_n = 1'b1;
        wait_cycles(25);
        chk("first_tick_edge", tk1, T - 1);
        chk("second_tick_edge", tk2, 2 * T - 1);

        // Clean press and release on channel 0.
        r0 = n_rise[0]; f0 = n_fall[0];
        btn_in[0] = 1'b1;
        wait_cycles(60);
        chk("press_rise_count", n_rise[0] - r0, 1);
        chk("press_level", btn_level[0], 1);
        btn_in[0] = 1'b0;
        wait_cycles(60);
        chk("release_fall_count", n_fall[0] - f0, 1);
        chk("release_level", btn_level[0], 0);

        // Bounce: a 14-cycle square wave never yields 4 equal samples.
        r0 = n_rise[0]; f0 = n_fall[0];
        for (int i = 0; i < 200 / 7; i++) begin
            btn_in[0] = ~btn_in[0];
            wait_cycles(7);
        end
        chk("bounce_rise", n_rise[0] - r0, 0);
        chk("bounce_fall", n_fall[0] - f0, 0);
        btn_in[0] = 1'b0;
        wait_cycles(60);

        // Long press twice.
        for (int p = 0; p < 2; p++) begin
            l0 = n_long[0];
            btn_in[0] = 1'b1;
            wait_cycles(17 * T);
            chk("long_count", n_long[0] - l0, 1);
            chk("long_delay", long_cyc[0] - rise_cyc[0], LONG * T);
            btn_in[0] = 1'b0;
            wait_cycles(60);
        end

        // Inverted channel 1 together with channel 0.
        chk("inv_idle_level", btn_level[1], 0);
        r0 = n_rise[0]; r1 = n_rise[1];
        btn_in = 2'b01;
        wait_cycles(60);
        chk("inv_rise_ch0", n_rise[0] - r0, 1);
        chk("inv_rise_ch1", n_rise[1] - r1, 1);
        chk("simul_rise", rise_cyc[1], rise_cyc[0]);
        btn_in = 2'b10;
        wait_cycles(60);

        // Reset after two high samples; four fresh samples needed afterwards.
        wait_ticks(1);
        btn_in[0] = 1'b1;
        wait_ticks(2);
        wait_cycles(1);
        reset_n = 1'b0;
        wait_cycles(3);
        chk("midreset_level", btn_level, 0);
        r0 = n_rise[0];
        reset_n = 1'b1;
        wait_cycles(6 * T);
        chk("midreset_rise_count", n_rise[0] - r0, 1);
        chk("midreset_rise_edge", rise_k[0], S * T);
        btn_in = 2'b10;
        wait_cycles(60);

        // Random segments, with occasional resets.
        for (int i = 0; i < 80; i++) begin
            btn_in = NCH'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) begin
                reset_n = 1'b0;
                wait_cycles(2);
                reset_n = 1'b1;
            end
            wait_cycles($urandom_range(1, 90));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
